// File: rtl/edge_list_packer.sv
// Edge list packer: collects one edge per beat into a 256 x 12-bit bus, then
// presents the whole graph (data, n, e) to the shortest-path engine.
module edge_list_packer #(
    parameter int MAX_EDGES = 255,
    parameter int ENTRY_W   = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [3:0]             s_parent,
    input  logic [3:0]             s_child,
    input  logic [3:0]             s_weight,
    input  logic                   s_last,
    input  logic [3:0]             n_in,
    output logic [256*ENTRY_W-1:0] m_data,
    output logic [3:0]             m_n,
    output logic [7:0]             m_e,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   err_ovf,
    output logic                   err_node
);

    // Handshakes: a beat transfers on a rising edge where valid && ready are both high.
    typedef enum logic {COLLECT, PRESENT} state_t;

    state_t      state, state_next;
    logic [7:0]  count;
    logic        first;
    logic        accept;
    logic        store;
    logic        node_bad;
    logic [3:0]  n_eff;
    logic [11:0] base;

    assign s_ready = (state == COLLECT);
    assign m_valid = (state == PRESENT);

    always_comb begin
        accept   = s_valid && (state == COLLECT);
        store    = accept && (count < 8'(MAX_EDGES));
        // The first beat checks against n_in directly since m_n is not latched yet.
        n_eff    = first ? n_in : m_n;
        node_bad = (s_parent >= n_eff) || (s_child >= n_eff);
        base     = 12'(count) * 12'(ENTRY_W);
    end

    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (accept && s_last) state_next = PRESENT;
            PRESENT: if (m_ready)          state_next = COLLECT;
            default:                       state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= COLLECT;
            m_data   <= '0;
            m_n      <= '0;
            m_e      <= '0;
            err_ovf  <= 1'b0;
            err_node <= 1'b0;
            count    <= '0;
            first    <= 1'b1;
        end else begin
            state <= state_next;
            if (accept) begin
                if (first) begin
                    m_n   <= n_in;
                    first <= 1'b0;
                end
                if (store) begin
                    m_data[base +: ENTRY_W] <= ENTRY_W'({s_weight, s_child, s_parent});
                    count <= count + 8'd1;
                end else begin
                    err_ovf <= 1'b1;
                end
                if (node_bad) err_node <= 1'b1;
                if (s_last)   m_e <= store ? count + 8'd1 : count;
            end
            if ((state == PRESENT) && m_ready) begin
                m_data   <= '0;
                count    <= '0;
                m_e      <= '0;
                err_ovf  <= 1'b0;
                err_node <= 1'b0;
                first    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_edge_list_packer.sv
// Bench for edge_list_packer: directed frames plus random frames checked
// against a frame-level model built from the list of offered edges.
module tb_edge_list_packer;

    localparam int W = 12;

    logic         clk = 1'b0;
    logic         reset;
    logic         s_valid;
    logic         s_ready;
    logic [3:0]   s_parent, s_child, s_weight;
    logic         s_last;
    logic [3:0]   n_in;
    logic [3071:0] m_data;
    logic [3:0]   m_n;
    logic [7:0]   m_e;
    logic         m_valid;
    logic         m_ready;
    logic         err_ovf;
    logic         err_node;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0]    bp[$], bc[$], bw[$];
    logic [W-1:0]  exp_q[$];
    logic [3071:0] exp_data;

    edge_list_packer dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_parent(s_parent), .s_child(s_child), .s_weight(s_weight),
        .s_last(s_last), .n_in(n_in),
        .m_data(m_data), .m_n(m_n), .m_e(m_e), .m_valid(m_valid),
        .m_ready(m_ready), .err_ovf(err_ovf), .err_node(err_node)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_data(input string tag, input logic [3071:0] exp);
        for (int k = 0; k < 48; k++)
            check($sformatf("%s[%0d]", tag, k), m_data[k*64 +: 64], exp[k*64 +: 64]);
    endtask

    // driver: one beat, waits (bounded) for s_ready then transfers on the next edge
    task automatic send_beat(input logic [3:0] p, input logic [3:0] c, input logic [3:0] w,
                             input logic last, input logic [3:0] n);
        int guard;
        guard    = 0;
        s_valid  = 1'b1;
        s_parent = p; s_child = c; s_weight = w; s_last = last; n_in = n;
        while (!s_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!s_ready) check("s_ready_timeout", 0, 1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Model: the first 255 offered edges are stored in order; later ones only flag overflow.
    task automatic run_frame(input logic [3:0] n, input int hold);
        int nb, ne;
        logic exp_ovf, exp_node;
        nb = bp.size();
        exp_q.delete();
        exp_node = 1'b0;
        for (int i = 0; i < nb; i++) begin
            if (i < 255) exp_q.push_back({bw[i], bc[i], bp[i]});
            if (bp[i] >= n || bc[i] >= n) exp_node = 1'b1;
        end
        ne       = exp_q.size();
        exp_ovf  = (nb > 255);
        exp_data = '0;
        foreach (exp_q[i]) exp_data[i*W +: W] = exp_q[i];

        for (int i = 0; i < nb; i++) begin
            // later beats carry a junk n_in: only the first beat's n counts
            send_beat(bp[i], bc[i], bw[i], i == nb - 1, (i == 0) ? n : 4'($urandom_range(0, 15)));
            if (i != nb - 1 && (i % 16 == 0)) check("m_valid_low_mid", m_valid, 0);
        end
        check("m_valid_lat1", m_valid, 1);
        check("s_ready_present", s_ready, 0);
        check("m_n", m_n, n);
        check("m_e", m_e, ne);
        check("err_ovf", err_ovf, exp_ovf);
        check("err_node", err_node, exp_node);
        check_data("m_data", exp_data);

        for (int h = 0; h < hold; h++) begin
            m_ready  = 1'b0;
            s_valid  = 1'($urandom_range(0, 1));
            s_parent = 4'($urandom); s_child = 4'($urandom); s_weight = 4'($urandom);
            s_last   = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check("hold_valid", m_valid, 1);
            check("hold_s_ready", s_ready, 0);
            check("hold_m_e", m_e, ne);
            check("hold_data", m_data == exp_data, 1);
            check("hold_errs", {err_ovf, err_node}, {exp_ovf, exp_node});
        end
        s_valid = 1'b0; s_last = 1'b0;

        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        check("post_valid", m_valid, 0);
        check("post_s_ready", s_ready, 1);
        check("post_m_e", m_e, 0);
        check("post_data_zero", |m_data, 0);
        check("post_errs", {err_ovf, err_node}, 0);
        bp.delete(); bc.delete(); bw.delete();
    endtask

    task automatic add_edge(input logic [3:0] p, input logic [3:0] c, input logic [3:0] w);
        bp.push_back(p); bc.push_back(c); bw.push_back(w);
    endtask

    initial begin
        s_valid = 0; s_parent = 0; s_child = 0; s_weight = 0; s_last = 0;
        n_in = 0; m_ready = 0;
        do_reset();
        check("rst_m_valid", m_valid, 0);
        check("rst_s_ready", s_ready, 1);
        check("rst_outs", {m_n, m_e, err_ovf, err_node}, 0);
        check("rst_data", |m_data, 0);

        // 3-edge frame
        add_edge(0, 1, 5); add_edge(0, 2, 3); add_edge(2, 1, 1);
        run_frame(4, 0);
        // same frame held for 10 cycles
        add_edge(0, 1, 5); add_edge(0, 2, 3); add_edge(2, 1, 1);
        exp_data = '0;
        run_frame(4, 10);
        check("t1_const", exp_data[35:0], 36'h112_320_510);

        // 257 beats, overflow
        for (int i = 0; i < 257; i++) add_edge(4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom));
        run_frame(8, 2);
        check("top_entry_zero", exp_data[3071:3060], 0);

        // node range error
        add_edge(1, 5, 2);
        run_frame(3, 1);
        check("t4_entry", exp_data[11:0], 12'h251);

        // reset mid-frame
        send_beat(1, 2, 3, 0, 5);
        send_beat(2, 3, 4, 0, 5);
        do_reset();
        check("midrst_outs", {m_n, m_e, err_ovf, err_node, m_valid}, 0);
        check("midrst_data", |m_data, 0);
        add_edge(3, 1, 9);
        run_frame(6, 0);

        // back-to-back 5 then 2
        for (int i = 0; i < 5; i++) add_edge(4'(i), 4'(i + 1), 4'(i + 7));
        run_frame(7, 0);
        add_edge(6, 0, 15); add_edge(0, 6, 14);
        run_frame(7, 0);

        // random frames
        for (int f = 0; f < 25; f++) begin
            int nb;
            logic [3:0] n;
            nb = (f == 12) ? $urandom_range(256, 300) : $urandom_range(1, 24);
            n  = 4'($urandom_range(1, 15));
            for (int i = 0; i < nb; i++)
                add_edge(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom));
            run_frame(n, $urandom_range(0, 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
